// File: rtl/sync_filter.sv
// Per-channel multi-flop synchroniser followed by a stable-count debounce filter.
// Define SYNC_FILTER_EDGE_EN to build the registered rise/fall pulse outputs.
module sync_filter #(
    parameter int unsigned      WIDTH   = 4,
    parameter int unsigned      STAGES  = 2,
    parameter int unsigned      FILTER  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int unsigned     CntW   = $clog2(FILTER + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync;
    logic [CntW-1:0]  cnt_q  [WIDTH];
    logic [CntW-1:0]  cnt_d  [WIDTH];
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] filt_d;

    assign sync = sync_q[STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                sync_q[s] <= RST_VAL;
            end
        end else if (ena_i) begin
            sync_q[0] <= data_in_i;
            for (int s = 1; s < int'(STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Any cycle where the synchronised level agrees with filt restarts the count,
    // so only an unbroken run of FILTER differing cycles can flip the output.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                filt_d[i] = sync[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= RST_VAL;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (ena_i) begin
            filt_q <= filt_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign data_out_o = filt_q;

`ifdef SYNC_FILTER_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Pulses are registered alongside filt so they line up with the data_out change.
    always_ff @(posedge clk_i) begin
        if (rst_i || !ena_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= filt_d & ~filt_q;
            fall_q <= ~filt_d & filt_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Randomised plus directed bench for sync_filter; three parameterisations share one stimulus
// and are compared every cycle against a sliding-window reference model.
module tb_sync_filter;

`ifdef SYNC_FILTER_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] data_in;
    logic [3:0] dout [3];
    logic [3:0] rise [3];
    logic [3:0] fall [3];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model state: h[d][k] is data_in captured k enabled edges ago.
    logic [3:0] h      [3][32];
    logic [3:0] m_out  [3];
    logic [3:0] m_rise [3];
    logic [3:0] m_fall [3];

    always #5 clk = ~clk;

    sync_filter #(.WIDTH(4), .STAGES(2), .FILTER(4), .RST_VAL(4'b0000)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_in_i(data_in),
        .data_out_o(dout[0]), .rise_o(rise[0]), .fall_o(fall[0])
    );

    sync_filter #(.WIDTH(4), .STAGES(3), .FILTER(1), .RST_VAL(4'b0000)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_in_i(data_in),
        .data_out_o(dout[1]), .rise_o(rise[1]), .fall_o(fall[1])
    );

    sync_filter #(.WIDTH(4), .STAGES(4), .FILTER(6), .RST_VAL(4'b1010)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .data_in_i(data_in),
        .data_out_o(dout[2]), .rise_o(rise[2]), .fall_o(fall[2])
    );

    function automatic int st_of(input int d);
        case (d)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int fl_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 6;
        endcase
    endfunction

    function automatic logic [3:0] rv_of(input int d);
        return (d == 2) ? 4'b1010 : 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Output flips once the synchronised level seen at the last FILTER enabled edges
    // has disagreed with it every time.
    task automatic model_step(input logic r, input logic e, input logic [3:0] din);
        for (int d = 0; d < 3; d++) begin
            m_rise[d] = '0;
            m_fall[d] = '0;
            if (r) begin
                for (int k = 0; k < 32; k++) h[d][k] = rv_of(d);
                m_out[d] = rv_of(d);
            end else if (e) begin
                for (int k = 31; k > 0; k--) h[d][k] = h[d][k-1];
                h[d][0] = din;
                for (int b = 0; b < 4; b++) begin
                    bit all_diff = 1'b1;
                    for (int j = 0; j < fl_of(d); j++) begin
                        if (h[d][st_of(d)+j][b] == m_out[d][b]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_out[d][b] = ~m_out[d][b];
                        if (m_out[d][b]) m_rise[d][b] = 1'b1;
                        else             m_fall[d][b] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] din);
        rst     = r;
        ena     = e;
        data_in = din;
        @(posedge clk);
        model_step(r, e, din);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model_out%0d", d), dout[d], m_out[d]);
            chk($sformatf("model_rise%0d", d), rise[d], EdgeEn ? m_rise[d] : 4'b0000);
            chk($sformatf("model_fall%0d", d), fall[d], EdgeEn ? m_fall[d] : 4'b0000);
        end
    endtask

    initial begin
        logic [3:0] din_r;

        // Reset state
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0000);
        chk("rst_out_a", dout[0], 4'b0000);
        chk("rst_out_c", dout[2], 4'b1010);
        chk("rst_rise_a", rise[0], 4'b0000);
        chk("rst_fall_c", fall[2], 4'b0000);
        step(1'b0, 1'b1, 4'b0000);
        chk("post_rst_rise", rise[0] | rise[1] | rise[2], 4'b0000);
        chk("post_rst_fall", fall[0] | fall[1] | fall[2], 4'b0000);

        // Single-channel rise latency: capture edge N, output at N+5
        step(1'b0, 1'b1, 4'b0001);
        repeat (3) step(1'b0, 1'b1, 4'b0001);
        step(1'b0, 1'b1, 4'b0001);
        chk("lat_a_n4", dout[0], 4'b0000);
        step(1'b0, 1'b1, 4'b0001);
        chk("lat_a_n5", dout[0], 4'b0001);
        chk("lat_a_rise", rise[0], EdgeEn ? 4'b0001 : 4'b0000);
        step(1'b0, 1'b1, 4'b0001);
        chk("lat_a_rise_gone", rise[0], 4'b0000);

        // Three-cycle glitch on channel 2 must be rejected
        repeat (3) step(1'b0, 1'b1, 4'b0101);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'b0001);
            chk("glitch_out", dout[0], 4'b0001);
            chk("glitch_edges", rise[0] | fall[0], 4'b0000);
        end

        // Freeze a partial count with ena low, then finish it
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 4'b0000);
            chk("hold_out", dout[0], 4'b0001);
        end
        step(1'b0, 1'b1, 4'b0000);
        chk("resume_n1", dout[0], 4'b0001);
        step(1'b0, 1'b1, 4'b0000);
        chk("resume_n2", dout[0], 4'b0000);
        chk("resume_fall", fall[0], EdgeEn ? 4'b0001 : 4'b0000);

        // All channels falling together, STAGES=3 FILTER=1
        repeat (12) step(1'b0, 1'b1, 4'b1111);
        chk("b_all_high", dout[1], 4'b1111);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0000);
        chk("b_n2", dout[1], 4'b1111);
        step(1'b0, 1'b1, 4'b0000);
        chk("b_n3", dout[1], 4'b0000);
        chk("b_fall", fall[1], EdgeEn ? 4'b1111 : 4'b0000);
        step(1'b0, 1'b1, 4'b0000);
        chk("b_fall_gone", fall[1], 4'b0000);

        // Reset mid-count on a non-zero RST_VAL instance, then re-filter from scratch
        repeat (14) step(1'b0, 1'b1, 4'b1010);
        chk("c_settled", dout[2], 4'b1010);
        step(1'b0, 1'b1, 4'b1011);
        step(1'b0, 1'b1, 4'b1011);
        step(1'b1, 1'b1, 4'b1011);
        chk("c_rst_out", dout[2], 4'b1010);
        chk("c_rst_edges", rise[2] | fall[2], 4'b0000);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 4'b1011);
            chk("c_refilter_wait", dout[2], 4'b1010);
            chk("c_refilter_edges", rise[2] | fall[2], 4'b0000);
        end
        step(1'b0, 1'b1, 4'b1011);
        chk("c_refilter_done", dout[2], 4'b1011);
        chk("c_refilter_rise", rise[2], EdgeEn ? 4'b0001 : 4'b0000);

        // Random phase: slowly toggling bits, mostly-enabled clock, rare resets
        din_r = 4'b1011;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) din_r[b] = ~din_r[b];
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), din_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 Parameter WIDTH, default 4: number of independent channels; legal range 1..32.
REQ-002 Parameter STAGES, default 2: synchroniser flop depth per channel; legal range 2..4.
REQ-003 Parameter FILTER, default 4: consecutive stable cycles required before the filtered output changes; legal range 1..255.
REQ-004 Parameter RST_VAL, default all-zero, WIDTH bits: reset value of every synchroniser stage and of data_out.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ena  input  1  clock enable; high = advance, low = hold.
REQ-008 data_in  input  WIDTH  asynchronous per-channel inputs.
REQ-009 data_out  output  WIDTH  synchronised, debounced level per channel.
REQ-010 rise  output  WIDTH  one-cycle pulse per channel on a 0->1 change of data_out.
REQ-011 fall  output  WIDTH  one-cycle pulse per channel on a 1->0 change of data_out.

Function
REQ-012 Each channel SHALL pass data_in[i] through a STAGES-deep flop chain; the last stage is sync[i].
REQ-013 Each channel SHALL hold a counter of width clog2(FILTER+1) and a filtered register filt[i] driving data_out[i].
REQ-014 With ena high and sync[i] == filt[i], cnt[i] SHALL clear to 0.
REQ-015 With ena high, sync[i] != filt[i] and cnt[i] < FILTER-1, cnt[i] SHALL increment by 1.
REQ-016 With ena high, sync[i] != filt[i] and cnt[i] == FILTER-1, filt[i] SHALL load sync[i] and cnt[i] SHALL clear.
REQ-017 FILTER == 1 SHALL update filt[i] on the first differing cycle (no counting).
REQ-018 A glitch on sync[i] shorter than FILTER cycles SHALL restart the count and leave data_out unchanged.
REQ-019 Latency: a data_in step set up before edge N SHALL appear on data_out after edge N+STAGES+FILTER-1 when ena is continuously high.
REQ-020 rise[i]/fall[i] SHALL be registered, asserting in the same cycle data_out[i] changes, for exactly one cycle.
REQ-021 With ena low, synchroniser stages, counters and filt SHALL hold their values; rise and fall SHALL be 0.
REQ-022 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-014..REQ-020.
REQ-023 The counter SHALL never exceed FILTER-1 and SHALL never wrap.

Reset
REQ-024 With rst high at posedge clk, all synchroniser stages and filt SHALL load RST_VAL, counters 0, rise and fall 0, regardless of ena.
REQ-025 rst asserted mid-count SHALL discard the partial count; no rise/fall pulse SHALL be issued for the aborted transition.
REQ-026 No pulse SHALL appear on rise or fall in the first cycle after rst deasserts.

Configuration
REQ-027 Macro SYNC_FILTER_EDGE_EN compiles in the edge-detect logic.
REQ-028 With SYNC_FILTER_EDGE_EN defined, rise and fall SHALL behave per REQ-020/REQ-021.
REQ-029 Without SYNC_FILTER_EDGE_EN, rise and fall SHALL remain as ports tied to constant 0, with no edge-detect flops; data_out behaviour is unchanged.

Verification
REQ-030 Defaults, reset, ena high, data_in 4'b0000 -> 4'b0001 held -> data_out 4'b0001 exactly 5 edges after the first capture edge; rise = 4'b0001 for one cycle (macro defined).
REQ-031 data_in[2] 3-cycle high glitch, FILTER=4 -> data_out stays 4'b0000, rise and fall stay 0.
REQ-032 ena low for 10 cycles during an in-progress count, data_in stable -> data_out and count frozen; transition completes after the remaining count once ena returns high.
REQ-033 rst pulsed 2 cycles after a change on data_in[0], RST_VAL=4'b1010 -> data_out 4'b1010 after reset, no pulses; input then re-filtered from scratch.
REQ-034 All channels toggled 1->0 together, FILTER=1, STAGES=3 -> data_out 4'b0000 3 edges after the first capture edge; fall = 4'b1111 for one cycle.
REQ-035 Build without SYNC_FILTER_EDGE_EN, repeat REQ-030 -> identical data_out timing, rise and fall constant 0.
